// File: rtl/filter_stream_feeder.sv
// Reads LEN words from memory and streams them into the trimmed-sum filter, then returns its result.
// Optional FEEDER_ALIGN_CHECK_EN: a misaligned base aborts the op with done+err instead of reading.
module filter_stream_feeder #(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      result_o,
  output logic             err_o,
  output logic             req_o,
  output logic [31:0]      addr_o,
  input  logic             addr_ok_i,
  input  logic             data_ok_i,
  input  logic [31:0]      rdata_i,
  output logic             filt_flush_o,
  output logic             filt_valid_o,
  output logic [31:0]      filt_data_o,
  input  logic [31:0]      filt_result_i
);

  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_CAPTURE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   received_q, received_d;
  logic [LEN_W-1:0]   pushed_q, pushed_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        mem_q [MAX_OUTST];
  logic [31:0]        mem_d [MAX_OUTST];
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               abort_q, abort_d;

  logic [LEN_W-1:0]   outstanding_c;
  logic               in_run_c, req_c, accept_c, push_c, pop_c;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      pushed_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      pushed_q   <= pushed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    pushed_d   = pushed_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    result_d   = result_q;
    abort_d    = abort_q;
    mem_d      = mem_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // Requests in flight plus buffered words never exceed the FIFO depth.
    outstanding_c = issued_q - received_q;
    in_run_c      = (state_q == S_RUN);
    req_c         = in_run_c && (issued_q < len_q) &&
                    ((outstanding_c + LEN_W'(count_q)) < LEN_W'(MAX_OUTST));
    accept_c      = req_c && addr_ok_i;
    push_c        = in_run_c && data_ok_i && (outstanding_c != '0);
    pop_c         = in_run_c && (count_q != '0) && !stall_i;

    if (accept_c) issued_d = issued_q + LEN_W'(1);
    if (push_c) begin
      mem_d[wr_ptr_q] = rdata_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      received_d      = received_q + LEN_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      pushed_d = pushed_q + LEN_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d     = base_addr_i & 32'hFFFF_FFFC;
          len_d      = len_i;
          issued_d   = '0;
          received_d = '0;
          pushed_d   = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          abort_d    = 1'b0;
`ifdef FEEDER_ALIGN_CHECK_EN
          if (base_addr_i[1:0] != 2'b00) begin
            abort_d = 1'b1;
            state_d = S_CAPTURE;
          end else begin
            state_d = S_FLUSH;
          end
`else
          state_d = S_FLUSH;
`endif
        end
      end
      S_FLUSH: state_d = (len_q == '0) ? S_CAPTURE : S_RUN;
      S_RUN: begin
        if (pop_c && (pushed_q == len_q - LEN_W'(1))) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Filter sum has settled one cycle after the final sample.
        result_d = abort_q ? 32'd0 : filt_result_i;
        done_d   = 1'b1;
        err_d    = abort_q;
        abort_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign result_o     = result_q;
  assign req_o        = req_c;
  assign addr_o       = base_q + (32'(issued_q) << 2);
  assign filt_flush_o = (state_q == S_FLUSH);
  assign filt_valid_o = pop_c;
  assign filt_data_o  = mem_q[rd_ptr_q];

  a_no_spurious_data: assert property (@(posedge clk_i) disable iff (reset_i)
    (data_ok_i && in_run_c) |-> (outstanding_c != '0));

endmodule

// File: tb/tb_filter_stream_feeder.sv
// Bench for filter_stream_feeder: bus responder, filter model and a per-cycle stream checker.
module tb_filter_stream_feeder;
  localparam int unsigned MAX_OUTST = 4;
  localparam int unsigned LEN_W     = 16;
`ifdef FEEDER_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic             clk, reset_i, start_i, stall_i;
  logic [31:0]      base_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             busy_o, done_o, err_o, req_o;
  logic [31:0]      result_o, addr_o;
  logic             addr_ok_i, data_ok_i;
  logic [31:0]      rdata_i;
  logic             filt_flush_o, filt_valid_o;
  logic [31:0]      filt_data_o, filt_result_i;

  filter_stream_feeder #(.MAX_OUTST(MAX_OUTST), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .stall_i(stall_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .err_o(err_o), .req_o(req_o), .addr_o(addr_o),
    .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .rdata_i(rdata_i),
    .filt_flush_o(filt_flush_o), .filt_valid_o(filt_valid_o),
    .filt_data_o(filt_data_o), .filt_result_i(filt_result_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trimmed-sum filter: sum minus max minus min once more than four samples are seen.
  int          f_cnt = 0;
  logic [31:0] f_sum = 0, f_max = 0, f_min = 0;
  always_ff @(posedge clk) begin
    if (filt_flush_o) begin
      f_cnt <= 0;
      f_sum <= 32'd0;
    end else if (filt_valid_o) begin
      f_cnt <= f_cnt + 1;
      f_sum <= f_sum + filt_data_o;
      f_max <= (f_cnt == 0 || filt_data_o > f_max) ? filt_data_o : f_max;
      f_min <= (f_cnt == 0 || filt_data_o < f_min) ? filt_data_o : f_min;
    end
  end
  assign filt_result_i = (f_cnt > 4) ? (f_sum - f_max - f_min) : 32'd0;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [31:0] data_tbl [16];

  bit          m_active = 0, m_abort = 0, flush_done = 0;
  logic [31:0] m_base = 0;
  int          m_len = 0, accepted = 0, returned = 0, popped = 0, m_cyc = 0;
  int          n_done = 0, done_cyc = 0;
  logic [31:0] done_res = 0;
  logic        done_err = 0, done_busy = 0;
  int          lat = 1, acc_delay = 0, req_wait = 0, stall_pct = 0;
  bit          burst = 0;

  typedef struct { logic [31:0] data; int ready; } pend_t;
  pend_t       pend_q[$];
  logic [31:0] acc_addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] tbl_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - m_base;
    return data_tbl[off[5:2]];
  endfunction

  function automatic logic [31:0] model_result(input int n);
    logic [31:0] s, mx, mn;
    if (n <= 4) return 32'd0;
    s = 0; mx = data_tbl[0]; mn = data_tbl[0];
    for (int i = 0; i < n; i++) begin
      s = s + data_tbl[i];
      if (data_tbl[i] > mx) mx = data_tbl[i];
      if (data_tbl[i] < mn) mn = data_tbl[i];
    end
    return s - mx - mn;
  endfunction

  // Bus responder, stall source and per-cycle stream checker.
  always @(negedge clk) begin
    bit exp_req, exp_valid;
    cyc++;
    addr_ok_i = 1'b0;
    if (req_o === 1'b1) begin
      if (req_wait >= acc_delay) begin addr_ok_i = 1'b1; req_wait = 0; end
      else req_wait++;
    end else req_wait = 0;
    data_ok_i = 1'b0;
    rdata_i   = 32'd0;
    if (pend_q.size() > 0 && pend_q[0].ready <= cyc && (!burst || $urandom_range(0, 1) == 1)) begin
      data_ok_i = 1'b1;
      rdata_i   = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    stall_i = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
    #1;
    if (m_active) m_cyc++;
    exp_req = m_active && flush_done && !m_abort && (accepted < m_len) &&
              ((accepted - popped) < int'(MAX_OUTST));
    check("req", 32'(req_o), 32'(exp_req));
    if (exp_req) check("addr", addr_o, m_base + 32'(accepted) * 4);
    exp_valid = m_active && flush_done && (returned > popped) && !stall_i;
    check("filt_valid", 32'(filt_valid_o), 32'(exp_valid));
    if (exp_valid && popped < 16) check("filt_data", filt_data_o, data_tbl[popped]);
    check("filt_flush", 32'(filt_flush_o), 32'(m_active && !m_abort && m_cyc == 1));
    if (!m_active) begin
      check("done_idle", 32'(done_o), 32'd0);
      check("busy_idle", 32'(busy_o), 32'd0);
      check("err_idle", 32'(err_o), 32'd0);
    end else if (done_o === 1'b1) begin
      n_done++;
      done_cyc  = m_cyc;
      done_res  = result_o;
      done_err  = err_o;
      done_busy = busy_o;
    end else if (m_cyc >= 1) begin
      check("busy_active", 32'(busy_o), 32'd1);
    end
    if (addr_ok_i && req_o === 1'b1 && m_active) begin
      acc_addr_q.push_back(addr_o);
      pend_q.push_back('{data: tbl_word(addr_o), ready: cyc + lat});
      accepted++;
    end
    if (data_ok_i && m_active) returned++;
    if (filt_valid_o === 1'b1 && m_active) popped++;
    if (filt_flush_o === 1'b1 && m_active) flush_done = 1;
    if (done_o === 1'b1) m_active = 0;
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && pend_q.size() > 0; i++) tick();
    check("bus_drain", 32'(pend_q.size()), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] base, input int len, input int t_lat, input int t_acc,
                        input bit t_burst, input int t_stall, input bit inject, input int exp_dc);
    int n0;
    lat = t_lat; acc_delay = t_acc; burst = t_burst; stall_pct = t_stall; req_wait = 0;
    m_base = base & 32'hFFFF_FFFC;
    m_len = len;
    m_abort = ALIGN_CHK && (base[1:0] != 2'b00);
    accepted = 0; returned = 0; popped = 0; m_cyc = 0; flush_done = 0;
    acc_addr_q.delete();
    n0 = n_done;
    start_i = 1'b1; base_addr_i = base; len_i = LEN_W'(len);
    m_active = 1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2000 && n_done == n0; i++) begin
      if (inject && i == 4) begin
        start_i = 1'b1; base_addr_i = 32'h0000_0500; len_i = LEN_W'(3);
      end else start_i = 1'b0;
      tick();
    end
    start_i = 1'b0;
    stall_pct = 0;
    check("done_seen", 32'(n_done - n0), 32'd1);
    check("result", done_res, m_abort ? 32'd0 : model_result(len));
    check("err", 32'(done_err), 32'(m_abort));
    check("busy_at_done", 32'(done_busy), 32'd0);
    check("n_req", 32'(accepted), m_abort ? 32'd0 : 32'(len));
    check("n_pop", 32'(popped), m_abort ? 32'd0 : 32'(len));
    if (exp_dc >= 0) check("done_latency", 32'(done_cyc), 32'(exp_dc));
    tick();
    check("result_hold", result_o, done_res);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; base_addr_i = 32'd0; len_i = '0; stall_i = 1'b0;
    addr_ok_i = 1'b0; data_ok_i = 1'b0; rdata_i = 32'd0;
    repeat (3) tick();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_flush", 32'(filt_flush_o), 32'd0);
    check("rst_valid", 32'(filt_valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_fdata", filt_data_o, 32'd0);
    reset_i = 1'b0;
    tick();

    // 8 words at 0x100 with 1-cycle latency; a second start mid-run must be ignored.
    data_tbl = '{5, 1, 9, 3, 7, 2, 8, 6, 0, 0, 0, 0, 0, 0, 0, 0};
    run_op(32'h0000_0100, 8, 1, 0, 1'b0, 0, 1'b1, -1);
    check("t1_result_lit", done_res, 32'd31);
    check("t1_first_addr", acc_addr_q[0], 32'h0000_0100);
    check("t1_last_addr", acc_addr_q[7], 32'h0000_011C);
    drain();

    // Zero-length op: flush only, done three cycles after the start cycle.
    run_op(32'h0000_0200, 0, 1, 0, 1'b0, 0, 1'b0, 3);
    check("t2_result_lit", done_res, 32'd0);

    // 16 words, slow address accept, bursty returns, 30% stall.
    data_tbl = '{12, 40, 7, 99, 3, 58, 21, 64, 17, 88, 5, 33, 76, 2, 45, 90};
    run_op(32'h0000_1000, 16, 2, 3, 1'b1, 30, 1'b0, -1);
    check("t3_result_lit", done_res, 32'd559);
    drain();

    // Address wrap past 2^32.
    data_tbl = '{10, 20, 30, 40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_op(32'hFFFF_FFF8, 4, 1, 0, 1'b0, 0, 1'b0, -1);
    check("t4_addr0", acc_addr_q[0], 32'hFFFF_FFF8);
    check("t4_addr1", acc_addr_q[1], 32'hFFFF_FFFC);
    check("t4_addr2", acc_addr_q[2], 32'h0000_0000);
    check("t4_addr3", acc_addr_q[3], 32'h0000_0004);
    check("t4_result_lit", done_res, 32'd0);
    drain();

    // Reset mid-run with reads still in flight; stale returns arrive while idle.
    data_tbl = '{12, 40, 7, 99, 3, 58, 21, 64, 17, 88, 5, 33, 76, 2, 45, 90};
    lat = 6; acc_delay = 0; burst = 0; stall_pct = 0;
    m_base = 32'h0000_2000; m_len = 16; m_abort = 0;
    accepted = 0; returned = 0; popped = 0; m_cyc = 0; flush_done = 0;
    start_i = 1'b1; base_addr_i = 32'h0000_2000; len_i = LEN_W'(16);
    m_active = 1;
    tick();
    start_i = 1'b0;
    repeat (6) tick();
    check("t5_inflight", 32'(pend_q.size() > 0), 32'd1);
    reset_i = 1'b1;
    m_active = 0;
    repeat (2) tick();
    reset_i = 1'b0;
    check("t5_busy_after_rst", 32'(busy_o), 32'd0);
    check("t5_req_after_rst", 32'(req_o), 32'd0);
    drain();
    run_op(32'h0000_3000, 6, 1, 0, 1'b0, 0, 1'b0, -1);
    check("t5_result_lit", done_res, 32'd117);
    drain();

    // Misaligned base.
    run_op(32'h0000_0102, 5, 1, 0, 1'b0, 0, 1'b0, ALIGN_CHK ? 2 : -1);
    if (ALIGN_CHK) begin
      check("t6_err_lit", 32'(done_err), 32'd1);
      check("t6_result_lit", done_res, 32'd0);
      check("t6_no_req", 32'(acc_addr_q.size()), 32'd0);
    end else begin
      check("t6_first_addr", acc_addr_q[0], 32'h0000_0100);
      check("t6_result_lit", done_res, 32'd59);
    end
    drain();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
